// File: rtl/traffic_sensor_conditioner_pkg.sv
// Shared defaults and light encodings for the traffic light controller family.
// The conditioner and the controller both pull their common constants from here.
package traffic_sensor_conditioner_pkg;

    localparam int DEF_DEB_CYCLES   = 4;
    localparam int DEF_STUCK_CYCLES = 1000;

    typedef enum logic [1:0] {
        LIGHT_R = 2'd0,
        LIGHT_Y = 2'd1,
        LIGHT_G = 2'd2
    } light_e;

endpackage

// File: rtl/traffic_sensor_channel.sv
// One detector channel: 2-flop synchroniser, debounce, demand latch cleared by
// the green acknowledge, and a sticky stuck-high flag that forces demand.
module traffic_sensor_channel
    import traffic_sensor_conditioner_pkg::*;
#(
    parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
    parameter int STUCK_CYCLES = DEF_STUCK_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic raw,
    input  logic grant,
    output logic demand,
    output logic stuck
);

    localparam int DEB_W   = $clog2(DEB_CYCLES);
    localparam int STUCK_W = $clog2(STUCK_CYCLES + 1);
    localparam logic [DEB_W-1:0]   DEB_MAX   = DEB_W'(DEB_CYCLES - 1);
    localparam logic [STUCK_W-1:0] STUCK_MAX = STUCK_W'(STUCK_CYCLES);

    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic               deb_level_q, deb_level_d;
    logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
    logic [STUCK_W-1:0] stuck_cnt_q, stuck_cnt_d;
    logic               stuck_q, stuck_d;
    logic               req_q, req_d;

    always_comb begin
        sync1_d     = raw;
        sync2_d     = sync1_q;
        deb_level_d = deb_level_q;
        deb_cnt_d   = '0;
        stuck_cnt_d = stuck_cnt_q;
        stuck_d     = stuck_q;
        req_d       = req_q;

        // Count consecutive disagreeing samples; accept the new level on the last one.
        if (sync2_q != deb_level_q) begin
            if (deb_cnt_q == DEB_MAX) begin
                deb_level_d = ~deb_level_q;
                deb_cnt_d   = '0;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end

        if (!deb_level_q) begin
            stuck_cnt_d = '0;
        end else if (enable && (stuck_cnt_q != STUCK_MAX)) begin
            stuck_cnt_d = stuck_cnt_q + STUCK_W'(1);
        end
        stuck_d = stuck_q | (stuck_cnt_d == STUCK_MAX);

        // A stuck detector keeps demanding so the road is never starved.
        if (!enable) begin
            req_d = 1'b0;
        end else if (stuck_q) begin
            req_d = 1'b1;
        end else if (grant) begin
            req_d = 1'b0;
        end else begin
            req_d = req_q | deb_level_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            deb_level_q <= 1'b0;
            deb_cnt_q   <= '0;
            stuck_cnt_q <= '0;
            stuck_q     <= 1'b0;
            req_q       <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            deb_level_q <= deb_level_d;
            deb_cnt_q   <= deb_cnt_d;
            stuck_cnt_q <= stuck_cnt_d;
            stuck_q     <= stuck_d;
            req_q       <= req_d;
        end
    end

    assign demand = req_q;
    assign stuck  = stuck_q;

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Conditions raw road A/B detectors into registered demands Sa/Sb for the
// traffic light controller; two independent channels, no logic at this level.
module traffic_sensor_conditioner
    import traffic_sensor_conditioner_pkg::*;
#(
    parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
    parameter int STUCK_CYCLES = DEF_STUCK_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic sa_raw,
    input  logic sb_raw,
    input  logic G_a,
    input  logic G_b,
    output logic Sa,
    output logic Sb,
    output logic stuck_a,
    output logic stuck_b
);

    traffic_sensor_channel #(
        .DEB_CYCLES   (DEB_CYCLES),
        .STUCK_CYCLES (STUCK_CYCLES)
    ) u_chan_a (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .raw    (sa_raw),
        .grant  (G_a),
        .demand (Sa),
        .stuck  (stuck_a)
    );

    traffic_sensor_channel #(
        .DEB_CYCLES   (DEB_CYCLES),
        .STUCK_CYCLES (STUCK_CYCLES)
    ) u_chan_b (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .raw    (sb_raw),
        .grant  (G_b),
        .demand (Sb),
        .stuck  (stuck_b)
    );

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Bench for traffic_sensor_conditioner: directed scenarios plus randomized traffic,
// checked every cycle against a window-based reference model through a scoreboard.
module tb_traffic_sensor_conditioner;

    localparam int DEB   = 4;
    localparam int STUCK = 20;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b1;
    logic sa_raw = 1'b0;
    logic sb_raw = 1'b0;
    logic G_a = 1'b0;
    logic G_b = 1'b0;
    logic Sa, Sb, stuck_a, stuck_b;

    int checks = 0;
    int failures = 0;

    traffic_sensor_conditioner #(
        .DEB_CYCLES   (DEB),
        .STUCK_CYCLES (STUCK)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .sa_raw  (sa_raw),
        .sb_raw  (sb_raw),
        .G_a     (G_a),
        .G_b     (G_b),
        .Sa      (Sa),
        .Sb      (Sb),
        .stuck_a (stuck_a),
        .stuck_b (stuck_b)
    );

    always #5 clk = ~clk;

    // Reference model: sync = raw two edges back; level flips once the last DEB
    // synced samples all disagree with it; demand/stuck follow the service rules.
    bit samp [2][$];
    bit syn  [2][$];
    bit m_level [2];
    int m_cnt   [2];
    bit m_stuck [2];
    bit m_req   [2];
    logic [3:0] exp_q [$];

    always @(posedge clk) begin
        bit raw_v, g_v, s, old_level, all_diff;
        for (int c = 0; c < 2; c++) begin
            raw_v = (c == 0) ? sa_raw : sb_raw;
            g_v   = (c == 0) ? G_a : G_b;
            if (!reset) begin
                samp[c] = {1'b0, 1'b0};
                syn[c]  = {};
                for (int i = 0; i < DEB; i++) syn[c].push_back(1'b0);
                m_level[c] = 0; m_cnt[c] = 0; m_stuck[c] = 0; m_req[c] = 0;
            end else begin
                s = samp[c][samp[c].size()-2];
                samp[c].push_back(raw_v);
                if (samp[c].size() > 4) void'(samp[c].pop_front());
                syn[c].push_back(s);
                if (syn[c].size() > DEB) void'(syn[c].pop_front());
                old_level = m_level[c];
                if (!enable)            m_req[c] = 0;
                else if (m_stuck[c])    m_req[c] = 1;
                else if (g_v)           m_req[c] = 0;
                else if (old_level)     m_req[c] = 1;
                if (!old_level)         m_cnt[c] = 0;
                else if (enable && m_cnt[c] < STUCK) m_cnt[c]++;
                if (m_cnt[c] == STUCK)  m_stuck[c] = 1;
                all_diff = 1;
                foreach (syn[c][i]) if (syn[c][i] == old_level) all_diff = 0;
                if (all_diff) m_level[c] = ~old_level;
            end
        end
        exp_q.push_back({m_req[0], m_req[1], m_stuck[0], m_stuck[1]});
    end

    // Monitor: outputs are presented every cycle; compare just after the edge.
    always begin
        logic [3:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({Sa, Sb, stuck_a, stuck_b} !== e) begin
                failures++;
                $display("FAIL scoreboard {Sa,Sb,stuck_a,stuck_b} actual=%b expected=%b t=%0t",
                         {Sa, Sb, stuck_a, stuck_b}, e, $time);
            end
        end
    end

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic a, input logic b);
        @(negedge clk);
        reset = 1'b0; sa_raw = a; sb_raw = b; G_a = 1'b0; G_b = 1'b0; enable = 1'b1;
        cyc(3);
        reset = 1'b1;
    endtask

    initial begin
        int hold_a, hold_b;

        // 1: reset held with detectors active, then release latency
        cyc(4);
        sa_raw = 1'b1; sb_raw = 1'b1;
        edges(3);
        chk("reset_Sa", Sa, 1'b0);
        chk("reset_Sb", Sb, 1'b0);
        chk("reset_stuck_a", stuck_a, 1'b0);
        chk("reset_stuck_b", stuck_b, 1'b0);
        @(negedge clk); reset = 1'b1;
        edges(6);
        chk("release_Sb_edge6", Sb, 1'b0);
        edges(1);
        chk("release_Sb_edge7", Sb, 1'b1);

        // 2: clean step on B
        do_reset(1'b0, 1'b0);
        cyc(4);
        sb_raw = 1'b1;
        edges(6);
        chk("step_Sb_edge6", Sb, 1'b0);
        edges(1);
        chk("step_Sb_edge7", Sb, 1'b1);
        edges(4);
        chk("step_Sb_hold", Sb, 1'b1);

        // 3: short pulse and bouncing on A
        do_reset(1'b0, 1'b0);
        cyc(3);
        sa_raw = 1'b1; cyc(3); sa_raw = 1'b0; cyc(4);
        for (int i = 0; i < 20; i++) begin sa_raw = ~sa_raw; cyc(1); end
        sa_raw = 1'b0;
        edges(8);
        chk("glitch_Sa", Sa, 1'b0);

        // 4: vehicle leaves before service, then served
        do_reset(1'b0, 1'b0);
        cyc(2);
        sa_raw = 1'b1; cyc(6); sa_raw = 1'b0;
        cyc(12);
        chk("latch_Sa_held", Sa, 1'b1);
        G_a = 1'b1;
        edges(1);
        chk("grant_clears_Sa", Sa, 1'b0);
        @(negedge clk); G_a = 1'b0;
        edges(5);
        chk("after_grant_Sa", Sa, 1'b0);

        // 5: stuck detector on B
        do_reset(1'b0, 1'b0);
        @(negedge clk); sb_raw = 1'b1;
        edges(25);
        chk("stuck_b_edge25", stuck_b, 1'b0);
        edges(1);
        chk("stuck_b_edge26", stuck_b, 1'b1);
        @(negedge clk); G_b = 1'b1;
        edges(2);
        chk("stuck_Sb_with_grant", Sb, 1'b1);
        @(negedge clk); sb_raw = 1'b0; G_b = 1'b0;
        edges(10);
        chk("stuck_b_sticky", stuck_b, 1'b1);

        // 6: enable drop mid-request and reset mid-debounce
        do_reset(1'b0, 1'b0);
        @(negedge clk); sa_raw = 1'b1;
        edges(7);
        chk("en_Sa_up", Sa, 1'b1);
        @(negedge clk); enable = 1'b0;
        edges(1);
        chk("en_low_Sa", Sa, 1'b0);
        @(negedge clk); enable = 1'b1;
        edges(1);
        chk("en_back_Sa", Sa, 1'b1);
        do_reset(1'b0, 1'b0);
        @(negedge clk); sa_raw = 1'b1;
        cyc(4);
        reset = 1'b0;
        cyc(2);
        reset = 1'b1;
        edges(6);
        chk("rst_mid_Sa_edge6", Sa, 1'b0);
        edges(1);
        chk("rst_mid_Sa_edge7", Sa, 1'b1);

        // Randomized traffic: level runs straddling the debounce and stuck limits
        do_reset(1'b0, 1'b0);
        hold_a = 0; hold_b = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (hold_a == 0) begin
                sa_raw = $urandom_range(0, 1);
                hold_a = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 30) : $urandom_range(1, 8);
            end
            if (hold_b == 0) begin
                sb_raw = $urandom_range(0, 1);
                hold_b = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 30) : $urandom_range(1, 8);
            end
            hold_a--; hold_b--;
            G_a    = ($urandom_range(0, 7) == 0);
            G_b    = ($urandom_range(0, 7) == 0);
            enable = ($urandom_range(0, 19) != 0);
            reset  = ($urandom_range(0, 299) != 0);
        end
        @(negedge clk); reset = 1'b1;
        edges(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
